// File: rtl/traffic_pkg.sv
// Shared phase encodings, FSM state type and default phase durations for the
// traffic phase scheduler.
package traffic_pkg;

    typedef enum logic [1:0] {
        PhPed = 2'd0,
        PhM1  = 2'd1,
        PhM2  = 2'd2,
        PhM3  = 2'd3
    } phase_e;

    typedef enum logic [2:0] {
        StM1,
        StM2,
        StM3,
        StPed,
        StClr
    } state_e;

    localparam int unsigned TM1Def  = 30;
    localparam int unsigned TM2Def  = 10;
    localparam int unsigned TM3Def  = 20;
    localparam int unsigned TPedDef = 30;
    localparam int unsigned TClrDef = 2;

    function automatic phase_e phase_of(state_e st);
        phase_e ph;
        case (st)
            StM2:    ph = PhM2;
            StM3:    ph = PhM3;
            StPed:   ph = PhPed;
            default: ph = PhM1;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter: holds at zero, done is high while the count reads zero.
module phase_timer #(
    parameter int unsigned Width  = 5,
    parameter int unsigned RstVal = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [Width-1:0] value_i,
    output logic             done_o
);

    logic [Width-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = value_i;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= Width'(RstVal);
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/phase_scheduler.sv
// Four-phase traffic scheduler with all-red clearance, latched pedestrian and
// approach-C requests, and registered light outputs.
module phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned T_M1  = TM1Def,
    parameter int unsigned T_M2  = TM2Def,
    parameter int unsigned T_M3  = TM3Def,
    parameter int unsigned T_PED = TPedDef,
    parameter int unsigned T_CLR = TClrDef
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       I,
    input  logic       car_c,
    output logic       a1,
    output logic       a2,
    output logic       b,
    output logic       c,
    output logic [1:0] mode,
    output logic       clr,
    output logic       walk,
    output logic       ped_pend
);

    localparam int unsigned TMaxA = (T_M1 > T_M2) ? T_M1 : T_M2;
    localparam int unsigned TMaxB = (T_M3 > T_PED) ? T_M3 : T_PED;
    localparam int unsigned TMaxC = (TMaxA > TMaxB) ? TMaxA : TMaxB;
    localparam int unsigned TMax  = (TMaxC > T_CLR) ? TMaxC : T_CLR;
    localparam int unsigned Width = (TMax > 1) ? $clog2(TMax) : 1;

    state_e           state_q, nxt_q;
    phase_e           mode_q;
    logic             a1_q, a2_q, b_q, c_q, walk_q, clr_q;
    logic             ped_q, car_q;
    logic             tmr_done;
    logic [Width-1:0] tmr_val;

    // Leaving a phase always starts clearance; leaving clearance starts the stored phase.
    always_comb begin
        tmr_val = Width'(T_CLR - 1);
        if (state_q == StClr) begin
            case (nxt_q)
                StM2:    tmr_val = Width'(T_M2 - 1);
                StM3:    tmr_val = Width'(T_M3 - 1);
                StPed:   tmr_val = Width'(T_PED - 1);
                default: tmr_val = Width'(T_M1 - 1);
            endcase
        end
    end

    phase_timer #(
        .Width  (Width),
        .RstVal (T_M1 - 1)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (tmr_done),
        .value_i(tmr_val),
        .done_o (tmr_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StM1;
            nxt_q   <= StM2;
            mode_q  <= PhM1;
            a1_q    <= 1'b1;
            a2_q    <= 1'b1;
            b_q     <= 1'b0;
            c_q     <= 1'b0;
            walk_q  <= 1'b0;
            clr_q   <= 1'b0;
            ped_q   <= 1'b0;
            car_q   <= 1'b0;
        end else begin
            if (I && state_q != StPed) ped_q <= 1'b1;
            if (car_c && state_q != StM3) car_q <= 1'b1;
            if (tmr_done) begin
                if (state_q == StClr) begin
                    state_q <= nxt_q;
                    mode_q  <= phase_of(nxt_q);
                    clr_q   <= 1'b0;
                    a1_q    <= (nxt_q == StM1);
                    a2_q    <= (nxt_q == StM1) || (nxt_q == StM2);
                    b_q     <= (nxt_q == StM2);
                    c_q     <= (nxt_q == StM3);
                    walk_q  <= (nxt_q == StPed);
                    // Later assignments win: entry clears beat same-cycle sets.
                    if (nxt_q == StPed) ped_q <= 1'b0;
                    if (nxt_q == StM3) car_q <= 1'b0;
                end else begin
                    state_q <= StClr;
                    clr_q   <= 1'b1;
                    a1_q    <= 1'b0;
                    a2_q    <= 1'b0;
                    b_q     <= 1'b0;
                    c_q     <= 1'b0;
                    walk_q  <= 1'b0;
                    case (state_q)
                        StM1:    nxt_q <= StM2;
                        StM2:    nxt_q <= ped_q ? StPed : (car_q ? StM3 : StM1);
                        default: nxt_q <= StM1;
                    endcase
                end
            end
        end
    end

    assign a1       = a1_q;
    assign a2       = a2_q;
    assign b        = b_q;
    assign c        = c_q;
    assign mode     = mode_q;
    assign clr      = clr_q;
    assign walk     = walk_q;
    assign ped_pend = ped_q;

endmodule
